via6522_lite: RTL and testbench
===============================

Name: via6522_lite

Overview:
- Parametrised 6522-style VIA for the 0xB8xx window, replacing the fixed 8'hB1 read stub and generalising the current crude PIA model.
- Provides two 8-bit ports with per-bit direction registers, two 16-bit timers, CA1/CB1 edge interrupts and a maskable IRQ.
- Runs on the CPU clock; one CPU access is presented per clock cycle.

Parameters:
- PB7_ENABLE, 1: 1 lets ACR[7] drive Timer 1 output onto PB7; 0 ties that feature off.
- PULSE_COUNT_ENABLE, 1: 1 lets ACR[5] clock Timer 2 from PB6 falling edges; 0 makes T2 always count clk.
- SYNC_STAGES, 2: synchroniser depth for ca1, cb1 and pb_in[6]; legal range 1..4.
- UNUSED_DOUT, 8'h00: read value for the SR register (0xA).

Ports:
- clk  in  1  CPU clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- cs  in  1  register access this cycle.
- rnw  in  1  1 = read, 0 = write.
- addr  in  4  register select.
- din  in  8  write data.
- dout  out  8  read data; combinational from addr.
- pa_in  in  8  port A pins.
- pa_out  out  8  ORA.
- pa_oe  out  8  DDRA.
- pb_in  in  8  port B pins.
- pb_out  out  8  ORB, with bit 7 optionally replaced by Timer 1 output.
- pb_oe  out  8  DDRB, with bit 7 forced to 1 when the PB7 timer output is enabled.
- ca1  in  1  interrupt edge input.
- cb1  in  1  interrupt edge input.
- irq  out  1  active-high, equals IFR[7].

Behaviour:
- Register map (addr):
  - 0 ORB/IRB; 1 ORA/IRA; 2 DDRB; 3 DDRA
  - 4 T1C-L; 5 T1C-H; 6 T1L-L; 7 T1L-H
  - 8 T2C-L; 9 T2C-H; A SR (read UNUSED_DOUT, writes ignored)
  - B ACR; C PCR; D IFR; E IER; F ORA (no flag clear)
- Reset values:
  - All registers, counters, latches, pb7_t1 and the armed flags are 0.
  - Outputs: pa_out = pa_oe = pb_out = pb_oe = 0, irq = 0.
  - Synchroniser flops are preset to the idle level of the selected edge.
  - reset has priority over any access in the same cycle.
- Port reads:
  - IRA = pa_in.
  - IRB = (pb_in & ~DDRB) | (ORB & DDRB).
  - When PB7 output is enabled (PB7_ENABLE && ACR[7]), IRB[7] = pb7_t1.
- Side effects occur on the rising edge where cs = 1, never on dout evaluation.
  - Read or write of addr 1 clears IFR[1].
  - Read or write of addr 0 clears IFR[4].
- IFR:
  - Bits: 6 = T1, 5 = T2, 4 = CB1, 1 = CA1; bits 0, 2, 3 read 0.
  - Bit 7 = |(IFR[6:0] & IER[6:0]).
  - Writing 1s to IFR clears the matching bits; din[7] is ignored.
- IER:
  - Write with din[7] = 1 sets the IER bits given by din[6:0]; din[7] = 0 clears them.
  - Read returns {1, IER[6:0]}.
- Priority when a flag is set and cleared in the same cycle:
  - A hardware set wins over a read/IFR-write clear.
  - A T1C-H or T2C-H write clear wins over a timer set.
- Timer 1:
  - T1C-L and T1L-L writes load latch_lo. T1L-H writes load latch_hi and clear IFR[6].
  - T1C-H write: latch_hi <= din, cnt <= {din, latch_lo}, armed <= 1, IFR[6] cleared, pb7_t1 <= 0.
  - Otherwise cnt decrements every clk.
  - When cnt == 0 and ACR[6] = 1 (free-run): cnt <= latch, IFR[6] set, pb7_t1 toggles. The period is latch + 1 clocks.
  - When cnt == 0 and ACR[6] = 0 (one-shot): cnt <= 16'hFFFF. If armed: IFR[6] set, pb7_t1 <= 1, armed <= 0.
  - Reading T1C-L clears IFR[6].
  - Reads of 4/5 return the live count; reads of 6/7 return the latch.
- Timer 2:
  - T2C-L write loads t2_lo.
  - T2C-H write: cnt <= {din, t2_lo}, armed <= 1, IFR[5] cleared.
  - Decrement event: every clk if ACR[5] = 0 (or PULSE_COUNT_ENABLE = 0); otherwise each synchronised falling edge of pb_in[6], one event per edge.
  - A decrement event at cnt == 0 wraps cnt to FFFF; if armed, IFR[5] is set and armed <= 0. One-shot only.
  - Reading T2C-L clears IFR[5].
- CA1/CB1:
  - Each input passes through a SYNC_STAGES synchroniser.
  - Active edge is set by PCR[0] (CA1) and PCR[4] (CB1): 0 = falling, 1 = rising.
  - The flag is set on the clk after the synchronised edge is detected.
- PCR and ACR bits not listed above are stored and readable but have no function.

Test Plan:
- DDR/port readback: write DDRB = F0, ORB = A5, pb_in = 3C → read addr 0 = AC; pb_oe = F0, pb_out = A5.
- T1 one-shot: IER ← C0, T1L-L ← 04, T1C-H ← 00 → irq rises 5 clks after the write; cnt reads FFFF then decrements; no second irq after a T1C-L read.
- T1 free-run with PB7: ACR ← C0, latch = 0003 → IFR[6] set and pb_out[7] toggled every 4 clks; pb_oe[7] = 1.
- T2 pulse count: ACR ← 20, T2C-L ← 02, T2C-H ← 00, apply 3 PB6 falling edges → IFR[5] set after the 3rd edge plus sync latency; only once.
- CA1 edge: PCR[0] = 1, IER ← 82, ca1 rises → irq = 1 exactly SYNC_STAGES + 1 clks later; read of addr 1 → irq = 0; read of addr F → irq unchanged.
- Collisions/reset: T1C-H write on the cycle cnt == 0 → IFR[6] stays clear, counter reloads; reset asserted mid-count → all outputs 0 on the next edge, no irq.

Source files
------------

// File: rtl/via6522_lite.sv
// via6522_lite: 6522-style VIA with two 8-bit ports, two 16-bit timers,
// CA1/CB1 edge interrupts and a maskable active-high irq.
module via6522_lite #(
  parameter bit         PB7_ENABLE         = 1'b1,
  parameter bit         PULSE_COUNT_ENABLE = 1'b1,
  parameter int         SYNC_STAGES        = 2,
  parameter logic [7:0] UNUSED_DOUT        = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rnw,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic [7:0] pa_oe,
  input  logic [7:0] pb_in,
  output logic [7:0] pb_out,
  output logic [7:0] pb_oe,
  input  logic       ca1,
  input  logic       cb1,
  output logic       irq
);
  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 1..4");
  end
  logic [7:0]  orb, ora, ddrb, ddra, acr, pcr, t1_ll, t1_lh, t2_lo, irb;
  logic [15:0] t1_cnt, t2_cnt;
  logic        t1_armed, t2_armed, pb7_t1;
  logic [6:0]  ifr, ier, ifr_set, ifr_clr, ifr_next;
  logic [2:0]  sync [SYNC_STAGES];
  logic [2:0]  prev, s;
  logic        wr, rd, pb7_en, t1_load, t2_load, t1_hit, t2_hit, t2_ev;
  logic        ca1_edge, cb1_edge;
  assign wr       = cs & ~rnw;
  assign rd       = cs & rnw;
  assign pb7_en   = PB7_ENABLE && acr[7];
  assign t1_load  = wr && addr == 4'h5;
  assign t2_load  = wr && addr == 4'h9;
  // s/prev: bit 0 = ca1, bit 1 = cb1, bit 2 = pb_in[6], after synchronisation
  assign s        = sync[SYNC_STAGES-1];
  assign ca1_edge = (s[0] ^ prev[0]) & (s[0] == pcr[0]);
  assign cb1_edge = (s[1] ^ prev[1]) & (s[1] == pcr[4]);
  assign t2_ev    = (PULSE_COUNT_ENABLE && acr[5]) ? prev[2] & ~s[2] : 1'b1;
  assign t1_hit   = ~t1_load && t1_cnt == '0 && (acr[6] || t1_armed);
  assign t2_hit   = ~t2_load && t2_ev && t2_cnt == '0 && t2_armed;
  assign ifr_set  = {t1_hit, t2_hit, cb1_edge, 2'b00, ca1_edge, 1'b0};
  assign ifr_clr  = {(rd && addr == 4'h4) || (wr && addr == 4'h7), rd && addr == 4'h8,
                     cs && addr == 4'h0, 2'b00, cs && addr == 4'h1, 1'b0}
                  | ((wr && addr == 4'hD) ? din[6:0] : 7'h00);
  // counter-high writes beat a simultaneous timer set; other clears lose to sets
  assign ifr_next = ((ifr & ~ifr_clr) | ifr_set) & ~{t1_load, t2_load, 5'b0} & 7'b111_0010;
  assign irq      = |(ifr & ier);
  assign irb      = {pb7_en ? pb7_t1 : (pb_in[7] & ~ddrb[7]) | (orb[7] & ddrb[7]),
                     (pb_in[6:0] & ~ddrb[6:0]) | (orb[6:0] & ddrb[6:0])};
  assign pa_out   = ora;
  assign pa_oe    = ddra;
  assign pb_out   = {pb7_en ? pb7_t1 : orb[7], orb[6:0]};
  assign pb_oe    = {pb7_en | ddrb[7], ddrb[6:0]};
  always_comb begin
    dout = UNUSED_DOUT;
    case (addr)
      4'h0:        dout = irb;
      4'h1, 4'hF:  dout = pa_in;
      4'h2:        dout = ddrb;
      4'h3:        dout = ddra;
      4'h4:        dout = t1_cnt[7:0];
      4'h5:        dout = t1_cnt[15:8];
      4'h6:        dout = t1_ll;
      4'h7:        dout = t1_lh;
      4'h8:        dout = t2_cnt[7:0];
      4'h9:        dout = t2_cnt[15:8];
      4'hB:        dout = acr;
      4'hC:        dout = pcr;
      4'hD:        dout = {irq, ifr};
      4'hE:        dout = {1'b1, ier};
      default:     dout = UNUSED_DOUT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {orb, ora, ddrb, ddra, acr, pcr, t1_ll, t1_lh, t2_lo} <= '0;
      {t1_cnt, t2_cnt, t1_armed, t2_armed, pb7_t1} <= '0;
      ifr  <= '0;
      ier  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= 3'b111;
      prev <= 3'b111;
    end else begin
      sync[0] <= {pb_in[6], cb1, ca1};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      prev <= s;
      ifr  <= ifr_next;
      if (wr) begin
        case (addr)
          4'h0:       orb   <= din;
          4'h1, 4'hF: ora   <= din;
          4'h2:       ddrb  <= din;
          4'h3:       ddra  <= din;
          4'h4, 4'h6: t1_ll <= din;
          4'h5, 4'h7: t1_lh <= din;
          4'h8:       t2_lo <= din;
          4'hB:       acr   <= din;
          4'hC:       pcr   <= din;
          4'hE:       ier   <= din[7] ? ier | din[6:0] : ier & ~din[6:0];
          default: ;
        endcase
      end
      if (t1_load) begin
        t1_cnt   <= {din, t1_ll};
        t1_armed <= 1'b1;
        pb7_t1   <= 1'b0;
      end else if (t1_cnt == '0 && acr[6]) begin
        t1_cnt <= {t1_lh, t1_ll};
        pb7_t1 <= ~pb7_t1;
      end else begin
        t1_cnt <= t1_cnt - 16'd1;
        if (t1_hit) begin
          pb7_t1   <= 1'b1;
          t1_armed <= 1'b0;
        end
      end
      if (t2_load) begin
        t2_cnt   <= {din, t2_lo};
        t2_armed <= 1'b1;
      end else if (t2_ev) begin
        t2_cnt <= t2_cnt - 16'd1;
        if (t2_hit) t2_armed <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_via6522_lite.sv
// tb_via6522_lite: random and directed register traffic scored against a behavioural VIA model.
module tb_via6522_lite;
  localparam int N = 2;
  logic       clk = 0, reset = 1, cs = 0, rnw = 1, ca1 = 1, cb1 = 1;
  logic [3:0] addr = 0;
  logic [7:0] din = 0, pa_in = 0, pb_in = 8'h40;
  logic [7:0] dout, pa_out, pa_oe, pb_out, pb_oe;
  logic       irq;
  via6522_lite #(.SYNC_STAGES(N)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rnw(rnw), .addr(addr), .din(din), .dout(dout),
    .pa_in(pa_in), .pa_out(pa_out), .pa_oe(pa_oe), .pb_in(pb_in), .pb_out(pb_out),
    .pb_oe(pb_oe), .ca1(ca1), .cb1(cb1), .irq(irq)
  );
  always #5 clk = ~clk;
  typedef struct { int sel; logic [7:0] exp; int cyc; } ent_t;
  ent_t sb[$];
  int total = 0, bad = 0, ncyc = 0;
  string nm [6] = '{"dout", "irq", "pa_out", "pa_oe", "pb_out", "pb_oe"};
  // reference model state
  bit [7:0]  m_orb, m_ora, m_ddrb, m_ddra, m_acr, m_pcr, m_t2lo;
  bit [15:0] m_t1, m_t1l, m_t2;
  bit        m_t1arm, m_t2arm, m_pb7;
  bit [6:0]  m_ifr, m_ier;
  bit [2:0]  hist[$];
  function automatic bit m_irq();
    return |(m_ifr & m_ier);
  endfunction
  function automatic logic [7:0] m_read(input logic [3:0] a);
    logic [7:0] irb;
    irb = (pb_in & ~m_ddrb) | (m_orb & m_ddrb);
    if (m_acr[7]) irb[7] = m_pb7;
    case (a)
      0: return irb;
      1, 15: return pa_in;
      2: return m_ddrb;
      3: return m_ddra;
      4: return m_t1[7:0];
      5: return m_t1[15:8];
      6: return m_t1l[7:0];
      7: return m_t1l[15:8];
      8: return m_t2[7:0];
      9: return m_t2[15:8];
      11: return m_acr;
      12: return m_pcr;
      13: return {m_irq(), m_ifr};
      14: return {1'b1, m_ier};
      default: return 8'h00;
    endcase
  endfunction
  task automatic push(input int sel, input logic [7:0] e);
    sb.push_back('{sel, e, ncyc});
  endtask
  task automatic step(input bit rs, input bit c, input bit r, input logic [3:0] a, input logic [7:0] d);
    bit w, rd, t1w, t2w, t1set, t2set, ca_ev, cb_ev, pulse;
    bit [6:0] clr;
    if (rs) begin
      {m_orb, m_ora, m_ddrb, m_ddra, m_acr, m_pcr, m_t2lo} = '0;
      {m_t1, m_t1l, m_t2, m_t1arm, m_t2arm, m_pb7, m_ifr, m_ier} = '0;
      hist.delete();
      repeat (N + 1) hist.push_back(3'b111);
      return;
    end
    w = c && !r; rd = c && r;
    t1w = w && a == 5; t2w = w && a == 9;
    // hist[1] is the pin value seen through the synchroniser now, hist[0] the one before
    ca_ev = hist[1][0] != hist[0][0] && hist[1][0] == m_pcr[0];
    cb_ev = hist[1][1] != hist[0][1] && hist[1][1] == m_pcr[4];
    pulse = hist[0][2] && !hist[1][2];
    t1set = 0; t2set = 0;
    if (t1w) begin
      m_t1 = {d, m_t1l[7:0]}; m_t1arm = 1; m_pb7 = 0;
    end else if (m_t1 == 0 && m_acr[6]) begin
      m_t1 = m_t1l; m_pb7 = !m_pb7; t1set = 1;
    end else begin
      if (m_t1 == 0 && m_t1arm) begin t1set = 1; m_pb7 = 1; m_t1arm = 0; end
      m_t1 = 16'((int'(m_t1) + 65535) % 65536);
    end
    if (t2w) begin
      m_t2 = {d, m_t2lo}; m_t2arm = 1;
    end else if (m_acr[5] ? pulse : 1'b1) begin
      if (m_t2 == 0 && m_t2arm) begin t2set = 1; m_t2arm = 0; end
      m_t2 = 16'((int'(m_t2) + 65535) % 65536);
    end
    clr = 0;
    if ((rd && a == 4) || (w && a == 7)) clr[6] = 1;
    if (rd && a == 8) clr[5] = 1;
    if (c && a == 0) clr[4] = 1;
    if (c && a == 1) clr[1] = 1;
    if (w && a == 13) clr = clr | d[6:0];
    m_ifr = m_ifr & ~clr;
    if (t1set) m_ifr[6] = 1;
    if (t2set) m_ifr[5] = 1;
    if (cb_ev) m_ifr[4] = 1;
    if (ca_ev) m_ifr[1] = 1;
    if (t1w) m_ifr[6] = 0;
    if (t2w) m_ifr[5] = 0;
    m_ifr = m_ifr & 7'h72;
    if (w) case (a)
      0: m_orb = d;
      1, 15: m_ora = d;
      2: m_ddrb = d;
      3: m_ddra = d;
      4, 6: m_t1l[7:0] = d;
      5, 7: m_t1l[15:8] = d;
      8: m_t2lo = d;
      11: m_acr = d;
      12: m_pcr = d;
      14: m_ier = d[7] ? m_ier | d[6:0] : m_ier & ~d[6:0];
      default: ;
    endcase
    hist.push_back({pb_in[6], cb1, ca1});
    void'(hist.pop_front());
  endtask
  task automatic cyc(input bit rs, input bit c, input bit r, input logic [3:0] a, input logic [7:0] d);
    reset = rs; cs = c; rnw = r; addr = a; din = d;
    if (c && r && !rs) push(0, m_read(a));
    @(posedge clk);
    step(rs, c, r, a, d);
    #1;
    push(1, {7'b0, m_irq()});
    push(2, m_ora);
    push(3, m_ddra);
    push(4, {m_acr[7] ? m_pb7 : m_orb[7], m_orb[6:0]});
    push(5, {m_acr[7] | m_ddrb[7], m_ddrb[6:0]});
    ncyc++;
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d); cyc(0, 1, 0, a, d); endtask
  task automatic rd(input logic [3:0] a); cyc(0, 1, 1, a, 8'h00); endtask
  task automatic idle(input int n); repeat (n) cyc(0, 0, 1, 4'h0, 8'h00); endtask
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      ent_t e;
      logic [7:0] act;
      e = sb.pop_front();
      case (e.sel)
        0: act = dout;
        1: act = {7'b0, irq};
        2: act = pa_out;
        3: act = pa_oe;
        4: act = pb_out;
        default: act = pb_oe;
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s cycle=%0d addr=%h got=%h want=%h", nm[e.sel], e.cyc, addr, act, e.exp);
      end
    end
  end
  initial begin
    repeat (3) cyc(1, 0, 1, 4'h0, 8'h00);
    // port readback
    wr(2, 8'hF0); wr(0, 8'hA5); pb_in = 8'h3C; rd(0); wr(3, 8'h5A); wr(1, 8'h33); rd(1); rd(15);
    pb_in = 8'h40;
    // T1 one-shot, then re-read after clearing
    wr(14, 8'hC0); wr(6, 8'h04); wr(5, 8'h00);
    repeat (3) begin rd(4); rd(5); end
    rd(13); rd(4); rd(5); rd(4); idle(6); rd(13);
    // T1 free-run with PB7
    wr(11, 8'hC0); wr(6, 8'h03); wr(7, 8'h00); wr(5, 8'h00);
    repeat (12) begin idle(1); rd(13); end
    // T2 pulse count
    wr(11, 8'h20); wr(14, 8'hA0); wr(8, 8'h02); wr(9, 8'h00);
    repeat (5) begin pb_in[6] = 0; idle(4); pb_in[6] = 1; idle(3); rd(13); rd(8); end
    // CA1 rising edge
    wr(11, 8'h00); wr(14, 8'h7F); wr(12, 8'h01); wr(14, 8'h82);
    ca1 = 0; idle(4); ca1 = 1; idle(N + 2); rd(15); rd(1); rd(13); ca1 = 0; idle(4);
    cb1 = 0; wr(14, 8'h90); idle(N + 2); rd(0);
    // T1C-H write on the cycle the counter reaches zero
    wr(14, 8'hC0); wr(6, 8'h03); wr(5, 8'h00); idle(3); wr(5, 8'h00); rd(13); idle(2); rd(4);
    // reset mid-count
    wr(11, 8'hC0); wr(2, 8'hFF); wr(0, 8'hFF); idle(2); cyc(1, 1, 0, 4'h5, 8'h00); rd(13); idle(3);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] a;
      logic [7:0] d;
      a = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      pa_in = 8'($urandom);
      if ($urandom_range(0, 5) == 0) ca1 = ~ca1;
      if ($urandom_range(0, 5) == 0) cb1 = ~cb1;
      if ($urandom_range(0, 2) == 0) pb_in[6] = ~pb_in[6];
      if ($urandom_range(0, 7) == 0) begin pb_in[7] = 1'($urandom); pb_in[5:0] = 6'($urandom); end
      cyc($urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0, 1'($urandom), a, d);
    end
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
